fetch_unit: RTL and testbench

Instruction fetch stage for the 16-bit WISC pipeline. It holds the PC, issues one instruction-memory read at a time, and presents the fetched instruction with its PC+2 to the decode stage through a valid/ready handshake. It absorbs branch and jump redirects from execute and halt notification from decode. When it has no valid instruction, it feeds decode a NOP.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_unit_pc_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FULL  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

    localparam logic [15:0] INSTR_NOP = 16'h0800;
    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam int          OPC_MSB   = 15;
    localparam int          OPC_LSB   = 11;

    function automatic logic is_halt_opcode(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with hold / +2 / redirect next-value selection.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_sel_t     i_sel,
    input  logic [15:0] i_redirect_pc,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_plus2
);

    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] w_redirect_aligned;

    // Instructions are halfword aligned, so a target's bit 0 is dropped.
    assign w_redirect_aligned = i_redirect_pc & 16'hFFFE;
    assign o_pc_plus2         = r_pc + 16'd2;
    assign o_pc               = r_pc;

    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_INC:      w_pc_next = o_pc_plus2;
            PC_REDIRECT: w_pc_next = w_redirect_aligned;
            default:     w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC & 16'hFFFE;
        end else begin
            r_pc <= w_pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// WISC fetch stage: one outstanding imem read, valid/ready to decode, redirect and halt.
// Optional FETCH_SELF_HALT_EN: a fetched HALT opcode stops fetch once decode accepts it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_dec,
    output logic        halted,
    output logic        err
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    pc_sel_t      w_pc_sel;
    logic [15:0]  w_pc;
    logic [15:0]  w_pc_plus2;
    logic [15:0]  r_stale_addr;
    logic [15:0]  r_instr;
    logic [15:0]  r_pc_plus2;
    logic         r_err;
    logic         w_load;
    logic         w_set_err;
`ifdef FETCH_SELF_HALT_EN
    logic         r_self_halt;
`endif

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sel         (w_pc_sel),
        .i_redirect_pc (redirect_pc),
        .o_pc          (w_pc),
        .o_pc_plus2    (w_pc_plus2)
    );

    // Redirect beats halt_dec everywhere: a HALT decoded alongside a redirect is wrong-path.
    always_comb begin
        w_next_state = r_state;
        w_pc_sel     = PC_HOLD;
        w_load       = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_set_err = imem_valid;
                if (redirect_valid) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_next_state = ST_REQ;
                end else if (halt_dec) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_next_state = imem_valid ? ST_REQ : ST_DRAIN;
                end else if (halt_dec) begin
                    w_next_state = ST_HALT;
                end else if (imem_valid) begin
                    w_load       = 1'b1;
                    w_pc_sel     = PC_INC;
                    w_next_state = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_next_state = imem_valid ? ST_REQ : ST_DRAIN;
                end else if (halt_dec) begin
                    w_next_state = ST_HALT;
                end else if (imem_valid) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_FULL: begin
                w_set_err = imem_valid;
                if (redirect_valid) begin
                    w_pc_sel     = PC_REDIRECT;
                    w_next_state = ST_REQ;
                end else if (halt_dec) begin
                    w_next_state = ST_HALT;
                end else if (instr_ready) begin
`ifdef FETCH_SELF_HALT_EN
                    w_next_state = r_self_halt ? ST_HALT : ST_REQ;
`else
                    w_next_state = ST_REQ;
`endif
                end
            end
            ST_HALT: begin
                w_set_err = imem_valid;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_stale_addr <= RESET_PC & 16'hFFFE;
            r_instr      <= INSTR_NOP;
            r_pc_plus2   <= 16'h0000;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_REQ) begin
                r_stale_addr <= w_pc;
            end
            if (w_load) begin
                r_instr    <= imem_data;
                r_pc_plus2 <= w_pc_plus2;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_SELF_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_self_halt <= 1'b0;
        end else if (w_load) begin
            r_self_halt <= is_halt_opcode(imem_data);
        end
    end
`endif

    // DRAIN keeps presenting the abandoned address while pc already holds the target.
    assign imem_req    = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign imem_addr   = (r_state == ST_DRAIN) ? r_stale_addr : w_pc;
    assign instr_valid = (r_state == ST_FULL);
    assign instruction = instr_valid ? r_instr : INSTR_NOP;
    assign pc_plus2    = r_pc_plus2;
    assign halted      = (r_state == ST_HALT);
    assign err         = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit (default build, FETCH_SELF_HALT_EN undefined).
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_dec;
    logic        halted;
    logic        err;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .pc_plus2       (pc_plus2),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_dec       (halt_dec),
        .halted         (halted),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [15:0] data;
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        hlt;
        logic        eReq;
        logic [15:0] eAddr;
        logic        eIv;
        logic [15:0] eInstr;
        logic [15:0] ePp2;
        logic        eHalted;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic [15:0] data, input logic rdy,
                                input logic rv, input logic [15:0] rpc, input logic hlt,
                                input logic eReq, input logic [15:0] eAddr, input logic eIv,
                                input logic [15:0] eInstr, input logic [15:0] ePp2,
                                input logic eHalted, input logic eErr);
        vec_t v;
        v.vld = vld;   v.data = data;   v.rdy = rdy;
        v.rv = rv;     v.rpc = rpc;     v.hlt = hlt;
        v.eReq = eReq; v.eAddr = eAddr; v.eIv = eIv;
        v.eInstr = eInstr; v.ePp2 = ePp2; v.eHalted = eHalted; v.eErr = eErr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        imem_valid     = v.vld;
        imem_data      = v.data;
        instr_ready    = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        halt_dec       = v.hlt;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d imem_req", idx),    {15'd0, imem_req},    {15'd0, v.eReq});
        checkOutput($sformatf("v%0d imem_addr", idx),   imem_addr,            v.eAddr);
        checkOutput($sformatf("v%0d instr_valid", idx), {15'd0, instr_valid}, {15'd0, v.eIv});
        checkOutput($sformatf("v%0d instruction", idx), instruction,          v.eInstr);
        checkOutput($sformatf("v%0d pc_plus2", idx),    pc_plus2,             v.ePp2);
        checkOutput($sformatf("v%0d halted", idx),      {15'd0, halted},      {15'd0, v.eHalted});
        checkOutput($sformatf("v%0d err", idx),         {15'd0, err},         {15'd0, v.eErr});
    endtask

    initial begin
        // Each row: inputs during a cycle, and the outputs expected in that same cycle.
        //                vld data     rdy rv rpc      hlt req addr     iv instr    pp2      h  e
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0)); // IDLE
        vecs.push_back(mk(1, 16'h4A21, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0)); // REQ 0000
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h4A21, 16'h0002, 0, 0)); // FULL
        vecs.push_back(mk(1, 16'h4A22, 1, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h0800, 16'h0002, 0, 0)); // REQ 0002
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h4A22, 16'h0004, 0, 0)); // stall 1
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h4A22, 16'h0004, 0, 0)); // stall 2
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h4A22, 16'h0004, 0, 0)); // stall 3
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h4A22, 16'h0004, 0, 0)); // ready back
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0041, 0, 1, 16'h0004, 0, 16'h0800, 16'h0004, 0, 0)); // REQ 0004, redirect
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0800, 16'h0004, 0, 0)); // DRAIN
        vecs.push_back(mk(1, 16'h1234, 0, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0800, 16'h0004, 0, 0)); // DRAIN stale resp
        vecs.push_back(mk(1, 16'h5555, 0, 0, 16'h0000, 0, 1, 16'h0040, 0, 16'h0800, 16'h0004, 0, 0)); // REQ 0040
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0100, 1, 0, 16'h0042, 1, 16'h5555, 16'h0042, 0, 0)); // FULL redirect+halt
        vecs.push_back(mk(1, 16'h7777, 0, 1, 16'hFFFF, 0, 1, 16'h0100, 0, 16'h0800, 16'h0042, 0, 0)); // REQ valid+redirect
        vecs.push_back(mk(1, 16'h6001, 0, 0, 16'h0000, 0, 1, 16'hFFFE, 0, 16'h0800, 16'h0042, 0, 0)); // REQ FFFE
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h6001, 16'h0000, 0, 0)); // wrapped
        vecs.push_back(mk(1, 16'h0003, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0, 0)); // REQ 0000, HALT word
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h0003, 16'h0002, 0, 0)); // HALT word shown
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0800, 16'h0002, 0, 0)); // fetch continues, halt_dec
        vecs.push_back(mk(1, 16'h9999, 0, 0, 16'h0000, 0, 0, 16'h0002, 0, 16'h0800, 16'h0002, 1, 0)); // HALT, late resp
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0002, 0, 16'h0800, 16'h0002, 1, 1)); // err sticky

        rst_n = 1'b0;
        applyStimulus(mk(0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0));
        @(negedge clk);
        #1;
        checkOutput("rst imem_req",    {15'd0, imem_req},    16'h0000);
        checkOutput("rst instruction", instruction,          16'h0800);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVec(i, vecs[i]);
            @(negedge clk);
        end

        // Asynchronous reset clears everything without waiting for an edge.
        applyStimulus(mk(0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async err",      {15'd0, err},    16'h0000);
        checkOutput("async halted",   {15'd0, halted}, 16'h0000);
        checkOutput("async pc_plus2", pc_plus2,        16'h0000);
        checkOutput("async addr",     imem_addr,       16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idle req", {15'd0, imem_req}, 16'h0000);
        @(negedge clk);
        #1;
        checkOutput("first req", {15'd0, imem_req}, 16'h0001);

        // Reset mid-request, then the orphaned response lands in IDLE.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreq reset req", {15'd0, imem_req}, 16'h0000);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_data  = 16'hDEAD;
        @(negedge clk);
        imem_valid = 1'b0;
        #1;
        checkOutput("idle resp err", {15'd0, err},         16'h0001);
        checkOutput("idle resp iv",  {15'd0, instr_valid}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("err held %0d", k), {15'd0, err}, 16'h0001);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("err cleared", {15'd0, err}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
